// File: rtl/pattern_sequencer_if.sv
// Control and raster bundle between the board-side controls and the pattern sequencer.
// master = control source (buttons/config), slave = sequencer.
interface pattern_sequencer_if;
  logic        auto_en;
  logic        pause;
  logic        step_req;
  logic [3:0]  mode;
  logic [10:0] hcnt;
  logic [11:0] vcnt;
  logic        de;
  logic        frame_start;
  logic        mode_change;

  modport master (
    output auto_en, pause, step_req,
    input  mode, hcnt, vcnt, de, frame_start, mode_change
  );

  modport slave (
    input  auto_en, pause, step_req,
    output mode, hcnt, vcnt, de, frame_start, mode_change
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Raster timing plus test-pattern mode control; the mode only changes on frame
// boundaries so the downstream pattern generator never tears a frame.
module pattern_sequencer #(
  parameter int H_TOTAL         = 2200,
  parameter int V_TOTAL         = 1125,
  parameter int H_ACTIVE        = 1920,
  parameter int V_ACTIVE        = 1080,
  parameter int FRAMES_PER_MODE = 60,
  parameter int NUM_MODES       = 4
) (
  input logic               clk,
  input logic               rst_n,
  pattern_sequencer_if.slave bus
);

  typedef enum logic [1:0] {MANUAL, AUTO, PAUSED} state_t;

  // Totals beyond what the counter widths can express are clamped to the width.
  localparam logic [10:0] H_LAST     = 11'((H_TOTAL > 2048) ? 2047 : H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'((V_TOTAL > 4096) ? 4095 : V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'((H_ACTIVE > 2048) ? 2048 : H_ACTIVE);
  localparam logic [12:0] V_ACT      = 13'((V_ACTIVE > 4096) ? 4096 : V_ACTIVE);
  localparam logic [7:0]  FPM_LAST   = 8'(FRAMES_PER_MODE - 1);
  localparam logic [3:0]  MODE_LAST  = 4'(NUM_MODES - 1);

  state_t      state;
  logic [10:0] hcnt;
  logic [11:0] vcnt;
  logic [7:0]  fcnt;
  logic [3:0]  mode;
  logic        step_pending;
  logic        de;
  logic        frame_start;
  logic        mode_change;

  logic [10:0] h_nxt;
  logic [11:0] v_nxt;
  logic [3:0]  mode_nxt;
  logic        fb;
  logic        step_now;
  logic        auto_fire;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    h_nxt     = hcnt + 11'd1;
    v_nxt     = vcnt;
    fb        = 1'b0;
    if (hcnt == H_LAST) begin
      h_nxt = '0;
      if (vcnt == V_LAST) begin
        v_nxt = '0;
        fb    = 1'b1;
      end else begin
        v_nxt = vcnt + 12'd1;
      end
    end
    // A request arriving exactly on the boundary cycle counts toward that boundary.
    step_now  = step_pending | bus.step_req;
    auto_fire = (state == AUTO) && bus.auto_en && !bus.pause && (fcnt == FPM_LAST);
    mode_nxt  = (mode == MODE_LAST) ? 4'd0 : mode + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MANUAL;
      hcnt         <= '0;
      vcnt         <= '0;
      fcnt         <= '0;
      mode         <= '0;
      step_pending <= 1'b0;
      de           <= 1'b0;
      frame_start  <= 1'b0;
      mode_change  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      hcnt        <= h_nxt;
      vcnt        <= v_nxt;
      // Decoded from the next counter values so they line up with the hcnt/vcnt they describe.
      de          <= ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      mode_change <= 1'b0;

      if (!fb) begin
        step_pending <= step_now;
      end else begin
        step_pending <= 1'b0;
        unique case (state)
          MANUAL: begin
            if (bus.auto_en) begin
              state <= AUTO;
              fcnt  <= '0;
            end
          end
          AUTO: begin
            if (!bus.auto_en) begin
              state <= MANUAL;
              fcnt  <= '0;
            end else if (bus.pause) begin
              state <= PAUSED;
              if (step_now) fcnt <= '0;
            end else if (auto_fire || step_now) begin
              fcnt <= '0;
            end else begin
              fcnt <= fcnt + 8'd1;
            end
          end
          PAUSED: begin
            if (!bus.auto_en) begin
              state <= MANUAL;
              fcnt  <= '0;
            end else if (!bus.pause) begin
              state <= AUTO;
            end
          end
          default: state <= MANUAL;
        endcase
        // Auto-advance and a pending step on the same boundary still move by one.
        if (step_now || auto_fire) begin
          mode        <= mode_nxt;
          mode_change <= 1'b1;
        end
      end
    end
  end

  assign bus.mode        = mode;
  assign bus.hcnt        = hcnt;
  assign bus.vcnt        = vcnt;
  assign bus.de          = de;
  assign bus.frame_start = frame_start;
  assign bus.mode_change = mode_change;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random control activity,
// every cycle compared against a frame-level reference model.
module tb_pattern_sequencer;
  localparam int HT    = 8;
  localparam int VT    = 4;
  localparam int HA    = 6;
  localparam int VA    = 3;
  localparam int FPM   = 3;
  localparam int NM    = 4;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n;

  pattern_sequencer_if bus();

  pattern_sequencer #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .FRAMES_PER_MODE(FPM), .NUM_MODES(NM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: elapsed cycles since reset release plus frame-level mode rules.
  int t;
  int m_mode;
  int m_frames;
  bit m_cycling;
  bit m_frozen;
  bit m_pending;
  bit m_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_mode = 0; m_frames = 0;
    m_cycling = 0; m_frozen = 0; m_pending = 0; m_mc = 0;
  endtask

  task automatic model_edge(input bit a, input bit p, input bit s);
    bit fb, step, fire;
    fb   = (t % FRAME) == FRAME - 1;
    t    = t + 1;
    m_mc = 0;
    fire = 0;
    if (!fb) begin
      m_pending = m_pending | s;
    end else begin
      step      = m_pending | s;
      m_pending = 0;
      if (!m_cycling) begin
        if (a) begin m_cycling = 1; m_frames = 0; end
      end else if (!m_frozen) begin
        if (!a) begin
          m_cycling = 0; m_frames = 0;
        end else if (p) begin
          m_frozen = 1;
          if (step) m_frames = 0;
        end else begin
          fire     = (m_frames == FPM - 1);
          m_frames = (fire || step) ? 0 : m_frames + 1;
        end
      end else begin
        if (!a) begin
          m_cycling = 0; m_frozen = 0; m_frames = 0;
        end else if (!p) begin
          m_frozen = 0;
        end
      end
      if (step || fire) begin
        m_mode = (m_mode + 1) % NM;
        m_mc   = 1;
      end
    end
  endtask

  task automatic compare_all();
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    check("hcnt", 32'(bus.hcnt), 32'(h));
    check("vcnt", 32'(bus.vcnt), 32'(v));
    check("de", 32'(bus.de), 32'((t > 0) && (h < HA) && (v < VA)));
    check("frame_start", 32'(bus.frame_start), 32'((t > 0) && (t % FRAME == 0)));
    check("mode", 32'(bus.mode), 32'(m_mode));
    check("mode_change", 32'(bus.mode_change), 32'(m_mc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hcnt"}, 32'(bus.hcnt), 0);
    check({tag, "_vcnt"}, 32'(bus.vcnt), 0);
    check({tag, "_mode"}, 32'(bus.mode), 0);
    check({tag, "_de"}, 32'(bus.de), 0);
    check({tag, "_fs"}, 32'(bus.frame_start), 0);
    check({tag, "_mc"}, 32'(bus.mode_change), 0);
  endtask

  // One clock: inputs are stable across the edge, outputs sampled on the falling edge.
  task automatic tick();
    bit a, p, s;
    a = bus.auto_en; p = bus.pause; s = bus.step_req;
    @(posedge clk);
    model_edge(a, p, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
  endtask

  task automatic run_to_fs(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame_start && n < 2 * FRAME);
    if (!bus.frame_start) check({tag, "_fs_timeout"}, 0, 1);
  endtask

  task automatic run_to_t(input int phase);
    int n;
    n = 0;
    while ((t % FRAME) != phase && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int cnt, prev, n;
    model_reset();
    rst_n        = 1'b0;
    bus.auto_en  = 1'b0;
    bus.pause    = 1'b0;
    bus.step_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    // Manual idle: frame timing and active-area size.
    cnt = 0; n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (bus.frame_start) n++;
      if (i >= FRAME && bus.de) cnt++;
    end
    check("idle_fs_count", 32'(n), 2);
    check("de_per_frame", 32'(cnt), 18);
    check("idle_mode", 32'(bus.mode), 0);

    // One step mid-frame, then three steps in one frame.
    run_to_t(10);
    pulse_step();
    run_to_fs("step1");
    check("step1_mode", 32'(bus.mode), 1);
    check("step1_mc", 32'(bus.mode_change), 1);
    tick();
    check("step1_mc_clear", 32'(bus.mode_change), 0);
    run_to_t(5);
    pulse_step(); tick(); pulse_step(); tick(); tick(); pulse_step();
    run_to_fs("step3");
    check("step3_mode", 32'(bus.mode), 2);

    // Auto cycling: entry at the next boundary, then one advance every FPM frames.
    run_to_t(12);
    bus.auto_en = 1'b1;
    run_to_fs("auto_entry");
    cnt = 0;
    for (int i = 0; i < 12 * FRAME; i++) begin
      tick();
      if (bus.mode_change) cnt++;
    end
    check("auto_adv_count", 32'(cnt), 4);

    // Pause with one frame already counted; the count must survive the pause.
    n = 0;
    while (!(m_frames == 1 && (t % FRAME) == 10) && n < 8 * FRAME) begin
      tick();
      n++;
    end
    check("pause_setup", 32'(m_frames), 1);
    bus.pause = 1'b1;
    run_to_fs("pause_entry");
    cnt = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick();
      if (bus.mode_change) cnt++;
    end
    check("paused_adv_count", 32'(cnt), 0);
    run_to_t(7);
    bus.pause = 1'b0;
    run_to_fs("resume");
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.mode_change && n < 4 * FRAME);
    check("resume_cycles", 32'(n), 2 * FRAME);

    // Step request on the very boundary where auto-advance fires.
    n = 0;
    while (!(m_cycling && !m_frozen && m_frames == FPM - 1 && (t % FRAME) == FRAME - 1)
           && n < 8 * FRAME) begin
      tick();
      n++;
    end
    prev = int'(bus.mode);
    pulse_step();
    check("fb_step_mode", 32'(bus.mode), 32'((prev + 1) % NM));
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.mode_change && n < 6 * FRAME);
    check("fb_step_restart", 32'(n), FPM * FRAME);

    // Random control activity against the model.
    for (int i = 0; i < 40 * FRAME; i++) begin
      if ($urandom_range(199) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(149) == 0) bus.pause = ~bus.pause;
      bus.step_req = ($urandom_range(24) == 0);
      tick();
    end
    bus.step_req = 1'b0;
    bus.auto_en  = 1'b0;
    bus.pause    = 1'b0;

    // Mid-line asynchronous reset with mode parked at 2.
    run_to_fs("park");
    for (int k = 0; k < 8 && m_mode != 2; k++) begin
      run_to_t(3);
      pulse_step();
      run_to_fs("park_step");
    end
    check("park_mode", 32'(bus.mode), 2);
    n = 0;
    while (!(bus.hcnt == 11'd5 && bus.vcnt == 12'd2) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame_start && n < 3 * FRAME);
    check("fs_after_rst", 32'(n), FRAME);
    check("mode_after_rst", 32'(bus.mode), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Timing and mode controller that drives the pattern generator's mode, hcnt and vcnt inputs.
- Generates raster counters and a data-enable signal.
- Advances the test-pattern mode only on frame boundaries, either automatically after a programmable frame count or on a manual step request.
- Sits between the board controls (buttons/config) and the pattern generator, so mode changes never tear a frame.

Parameters:
H_TOTAL, 2200, pixels per line including blanking (max 2048 usable by 11-bit hcnt; set ≤2048 in practice, 2048 cap enforced by width)
V_TOTAL, 1125, lines per frame including blanking
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
FRAMES_PER_MODE, 60, frames each mode is held in AUTO (1..255)
NUM_MODES, 4, number of valid modes; mode wraps NUM_MODES-1 -> 0

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
auto_en  in  1  level; 1 = automatic cycling, 0 = manual
pause  in  1  level; freezes automatic cycling (AUTO only)
step_req  in  1  single-cycle pulse; request advance to next mode
mode  out  4  current pattern mode to pattern generator
hcnt  out  11  horizontal pixel counter
vcnt  out  12  vertical line counter
de  out  1  1 when hcnt<H_ACTIVE and vcnt<V_ACTIVE
frame_start  out  1  one-cycle pulse when hcnt==0 and vcnt==0
mode_change  out  1  one-cycle pulse in the cycle mode takes a new value

Behaviour:
- Reset (rst_n=0, asynchronous): hcnt=0, vcnt=0, mode=0, de=0, frame_start=0, mode_change=0, frame counter=0, step_pending=0, FSM=MANUAL.
- Raster:
  - hcnt increments each clk and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
- Outputs are registered:
  - de and frame_start are decoded from next-state counter values, so they align with the hcnt/vcnt they describe (zero relative latency).
- Frame boundary (FB): cycle where hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1. A mode update decided at FB appears on mode in the same cycle hcnt/vcnt become 0, coincident with frame_start. Pattern generator's 1-cycle register latency is downstream's concern.
- step_req: any pulse sets step_pending. step_pending clears at the next FB, where it contributes one advance. Multiple pulses within one frame yield one advance. A pulse exactly at FB counts toward that FB.
- FSM states: MANUAL, AUTO, PAUSED.
  - State transitions are evaluated at FB only; otherwise the state holds.
  - MANUAL: auto_en=1 at FB -> AUTO, frame counter cleared. Mode advances only via step_pending.
  - AUTO:
    - Frame counter increments at each FB.
    - When it reaches FRAMES_PER_MODE-1 at FB: advance mode, counter -> 0.
    - auto_en=0 at FB -> MANUAL, counter -> 0.
    - pause=1 at FB -> PAUSED, counter held.
  - PAUSED: counter frozen. pause=0 at FB -> AUTO. auto_en=0 at FB -> MANUAL (priority over pause).
- Simultaneous events at one FB: the auto-advance and step_pending together advance mode by exactly one (no double step). step_pending is also honoured in AUTO and PAUSED; in AUTO it resets the frame counter to 0.
- Advance: mode <= (mode==NUM_MODES-1) ? 0 : mode+1. mode_change pulses for 1 cycle on every advance.
- Width rules: hcnt 11b, vcnt 12b, frame counter 8b, unsigned compares only.
- Reset mid-frame: all state and counters return to reset values immediately. The next frame_start occurs H_TOTAL*V_TOTAL cycles after reset release.
- Input synchronisation of auto_en, pause and step_req is done upstream; this block does no debounce.

Test Plan:
- Reset release, auto_en=0, small params (H_TOTAL=8, V_TOTAL=4, H_ACTIVE=6, V_ACTIVE=3) -> frame_start every 32 cycles; de high for 18 of 32 cycles per frame; mode stays 0.
- MANUAL, step_req pulse mid-frame -> mode 0->1 exactly at next frame_start with mode_change=1 for one cycle; three pulses in one frame -> single advance.
- auto_en=1, FRAMES_PER_MODE=3, NUM_MODES=4 -> mode sequence 0,1,2,3,0 advancing every 3 frames; wrap 3->0 verified.
- AUTO with pause=1 for 5 frames, then 0 -> no advance during pause; frame counter resumes from its held value.
- step_req at the same FB as auto-advance -> mode increments by exactly 1; frame counter restarts at 0.
- rst_n asserted mid-line at hcnt=5, vcnt=2, mode=2 -> all outputs 0 asynchronously; after release, first frame_start 32 cycles later with mode=0.
